// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver and scan-code-set-2 decoder feeding the key-unlock
// controller's passphrase input.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   ps2_clk_i     raw PS/2 clock from the keyboard (asynchronous)
//   ps2_dat_i     raw PS/2 data from the keyboard (asynchronous)
//   ps2_data_o    ASCII byte, meaningful when ps2_valid_o=1, held otherwise
//   ps2_valid_o   one-cycle key event strobe
//   ps2_done_o    Enter indication, two cycles starting with the strobe
//   ps2_reset_o   Escape indication, coincident with the strobe
//   ps2_err_o     one-cycle pulse on start/parity/stop/timeout error
//
// Optional build macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat make
// codes until the key's break code is seen.
module ps2_kbd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] ps2_data_o,
  output logic       ps2_valid_o,
  output logic       ps2_done_o,
  output logic       ps2_reset_o,
  output logic       ps2_err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} frame_state_t;
  typedef enum logic [1:0] {NORM, BRK, EXT, EXTBRK} dec_state_t;

  // Make code to {mapped, lowercase ASCII}
  function automatic logic [8:0] xlate(input logic [7:0] c);
    case (c)
      8'h1C: xlate = {1'b1, 8'h61}; 8'h32: xlate = {1'b1, 8'h62};
      8'h21: xlate = {1'b1, 8'h63}; 8'h23: xlate = {1'b1, 8'h64};
      8'h24: xlate = {1'b1, 8'h65}; 8'h2B: xlate = {1'b1, 8'h66};
      8'h34: xlate = {1'b1, 8'h67}; 8'h33: xlate = {1'b1, 8'h68};
      8'h43: xlate = {1'b1, 8'h69}; 8'h3B: xlate = {1'b1, 8'h6A};
      8'h42: xlate = {1'b1, 8'h6B}; 8'h4B: xlate = {1'b1, 8'h6C};
      8'h3A: xlate = {1'b1, 8'h6D}; 8'h31: xlate = {1'b1, 8'h6E};
      8'h44: xlate = {1'b1, 8'h6F}; 8'h4D: xlate = {1'b1, 8'h70};
      8'h15: xlate = {1'b1, 8'h71}; 8'h2D: xlate = {1'b1, 8'h72};
      8'h1B: xlate = {1'b1, 8'h73}; 8'h2C: xlate = {1'b1, 8'h74};
      8'h3C: xlate = {1'b1, 8'h75}; 8'h2A: xlate = {1'b1, 8'h76};
      8'h1D: xlate = {1'b1, 8'h77}; 8'h22: xlate = {1'b1, 8'h78};
      8'h35: xlate = {1'b1, 8'h79}; 8'h1A: xlate = {1'b1, 8'h7A};
      8'h45: xlate = {1'b1, 8'h30}; 8'h16: xlate = {1'b1, 8'h31};
      8'h1E: xlate = {1'b1, 8'h32}; 8'h26: xlate = {1'b1, 8'h33};
      8'h25: xlate = {1'b1, 8'h34}; 8'h2E: xlate = {1'b1, 8'h35};
      8'h36: xlate = {1'b1, 8'h36}; 8'h3D: xlate = {1'b1, 8'h37};
      8'h3E: xlate = {1'b1, 8'h38}; 8'h46: xlate = {1'b1, 8'h39};
      8'h29: xlate = {1'b1, 8'h20}; 8'h5A: xlate = {1'b1, 8'h0D};
      8'h76: xlate = {1'b1, 8'h1B};
      default: xlate = 9'h000;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  frame_state_t           frame_state, frame_state_n;
  dec_state_t             dec_state, dec_state_n;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic [9:0]             shreg, shreg_n;
  logic [CNT_W-1:0]       to_cnt, to_cnt_n;
  logic                   lshift, lshift_n, rshift, rshift_n;
  logic [7:0]             data_n;
  logic                   valid_n, done_n, reset_n, err_n;
  logic [7:0]             last_make, last_make_n;

  logic       clk_s, dat_s, fall;
  logic [7:0] code;
  logic [8:0] xl;
  logic       emit;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;
  assign code  = shreg[7:0];
  assign xl    = xlate(code);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync    <= '1;
      dat_sync    <= '1;
      clk_prev    <= 1'b1;
      frame_state <= IDLE;
      dec_state   <= NORM;
      bit_cnt     <= 4'd0;
      shreg       <= 10'd0;
      to_cnt      <= '0;
      lshift      <= 1'b0;
      rshift      <= 1'b0;
      last_make   <= 8'h00;
      ps2_data_o  <= 8'h00;
      ps2_valid_o <= 1'b0;
      ps2_done_o  <= 1'b0;
      ps2_reset_o <= 1'b0;
      ps2_err_o   <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync    <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev    <= clk_s;
      frame_state <= frame_state_n;
      dec_state   <= dec_state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      to_cnt      <= to_cnt_n;
      lshift      <= lshift_n;
      rshift      <= rshift_n;
      last_make   <= last_make_n;
      ps2_data_o  <= data_n;
      ps2_valid_o <= valid_n;
      ps2_done_o  <= done_n;
      ps2_reset_o <= reset_n;
      ps2_err_o   <= err_n;
    end
  end

  // Frame reception, decode and translate
  always_comb begin
    frame_state_n = frame_state;
    dec_state_n   = dec_state;
    bit_cnt_n     = bit_cnt;
    shreg_n       = shreg;
    lshift_n      = lshift;
    rshift_n      = rshift;
    last_make_n   = last_make;
    data_n        = ps2_data_o;
    valid_n       = 1'b0;
    // Second cycle of the Enter done pulse
    done_n        = ps2_valid_o & ps2_done_o;
    reset_n       = 1'b0;
    err_n         = 1'b0;
    emit          = 1'b0;
    to_cnt_n      = fall ? '0 : ((to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1);

    case (frame_state)
      IDLE: begin
        if (fall) begin
          if (!dat_s) begin
            frame_state_n = RECV;
            bit_cnt_n     = 4'd0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RECV: begin
        if (fall) begin
          // Data, parity, stop arrive in that order; stop ends up in bit 9
          shreg_n   = {dat_s, shreg[9:1]};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) frame_state_n = CHECK;
        end else if (to_cnt == TO_MAX) begin
          frame_state_n = IDLE;
          err_n         = 1'b1;
        end
      end
      CHECK: begin
        frame_state_n = IDLE;
        if ((^shreg[8:0]) && shreg[9]) begin
          case (dec_state)
            NORM: begin
              if (code == 8'hF0)      dec_state_n = BRK;
              else if (code == 8'hE0) dec_state_n = EXT;
              else if (code == 8'h12) lshift_n = 1'b1;
              else if (code == 8'h59) rshift_n = 1'b1;
              else begin
                emit = xl[8];
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (code == last_make) emit = 1'b0;
                else last_make_n = code;
`endif
              end
            end
            BRK: begin
              if (code == 8'h12) lshift_n = 1'b0;
              if (code == 8'h59) rshift_n = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
              if (code == last_make) last_make_n = 8'h00;
`endif
              dec_state_n = NORM;
            end
            EXT:     dec_state_n = (code == 8'hF0) ? EXTBRK : NORM;
            default: dec_state_n = NORM;
          endcase
        end else begin
          err_n = 1'b1;
        end
      end
      default: frame_state_n = IDLE;
    endcase

    if (emit) begin
      valid_n = 1'b1;
      data_n  = xl[7:0];
      if ((lshift | rshift) && (xl[7:0] >= 8'h61) && (xl[7:0] <= 8'h7A))
        data_n = xl[7:0] - 8'h20;
      if (code == 8'h5A) done_n  = 1'b1;
      if (code == 8'h76) reset_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder: bit-bangs PS/2 frames and checks the
// strobes, Enter/Escape indications and error pulses against hand values.
module tb_ps2_kbd_decoder;

  localparam int unsigned TO   = 300;
  localparam int          HALF = 20;
  localparam int          GAP  = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] ps2_data_o;
  logic       ps2_valid_o, ps2_done_o, ps2_reset_o, ps2_err_o;

  ps2_kbd_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
    .ps2_data_o(ps2_data_o), .ps2_valid_o(ps2_valid_o), .ps2_done_o(ps2_done_o),
    .ps2_reset_o(ps2_reset_o), .ps2_err_o(ps2_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Output monitor, sampled on the falling clk edge
  logic [7:0] q_data[$];
  logic       q_done[$];
  logic       q_rst[$];
  int  err_cnt = 0, done_cyc = 0, rst_cyc = 0;
  logic prev_vd = 1'b0, prev2_vd = 1'b0;
  logic after1_valid = 1'b1, after1_done = 1'b0, after2_done = 1'b1;

  initial forever begin
    @(negedge clk);
    if (ps2_valid_o) begin
      q_data.push_back(ps2_data_o);
      q_done.push_back(ps2_done_o);
      q_rst.push_back(ps2_reset_o);
    end
    if (ps2_err_o)   err_cnt++;
    if (ps2_done_o)  done_cyc++;
    if (ps2_reset_o) rst_cyc++;
    if (prev2_vd) after2_done = ps2_done_o;
    if (prev_vd) begin
      after1_valid = ps2_valid_o;
      after1_done  = ps2_done_o;
    end
    prev2_vd = prev_vd;
    prev_vd  = ps2_valid_o & ps2_done_o;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    wait_clks(GAP);
  endtask

  int base, e0, d0, r0;

  initial begin
    wait_clks(5);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_valid", 32'(ps2_valid_o), 32'd0);
    check("rst_data",  32'(ps2_data_o),  32'd0);
    check("rst_done",  32'(ps2_done_o),  32'd0);
    check("rst_reset", 32'(ps2_reset_o), 32'd0);
    check("rst_err",   32'(ps2_err_o),   32'd0);

    // 'a' make then break
    base = q_data.size(); e0 = err_cnt;
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("a_count", 32'(q_data.size() - base), 32'd1);
    check("a_data",  32'(q_data[base]), 32'h61);
    check("a_done",  32'(q_done[base]), 32'd0);
    check("a_reset", 32'(q_rst[base]),  32'd0);
    check("a_noerr", 32'(err_cnt - e0), 32'd0);

    // Shifted 'B' then unshifted 'b'
    base = q_data.size();
    send_frame(8'h12, 1'b0);
    send_frame(8'h32, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h32, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h12, 1'b0);
    send_frame(8'h32, 1'b0);
    check("b_count", 32'(q_data.size() - base), 32'd2);
    check("B_upper", 32'(q_data[base]),   32'h42);
    check("b_lower", 32'(q_data[base+1]), 32'h62);
    check("b_hold",  32'(ps2_data_o),     32'h62);

    // Right shift does not affect digits; break 0x59 clears it
    base = q_data.size();
    send_frame(8'h59, 1'b0);
    send_frame(8'h16, 1'b0);
    send_frame(8'h15, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h59, 1'b0);
    send_frame(8'h15, 1'b0);
    check("rs_count", 32'(q_data.size() - base), 32'd3);
    check("rs_digit", 32'(q_data[base]),   32'h31);
    check("rs_Q",     32'(q_data[base+1]), 32'h51);
    check("rs_q",     32'(q_data[base+2]), 32'h71);

    // Extended make/break is silent
    base = q_data.size();
    send_frame(8'hE0, 1'b0);
    send_frame(8'h70, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h70, 1'b0);
    check("ext_silent", 32'(q_data.size() - base), 32'd0);

    // Enter: two-cycle done starting with the strobe
    base = q_data.size(); d0 = done_cyc;
    send_frame(8'h5A, 1'b0);
    check("ent_count",  32'(q_data.size() - base), 32'd1);
    check("ent_data",   32'(q_data[base]), 32'h0D);
    check("ent_done0",  32'(q_done[base]), 32'd1);
    check("ent_valid1", 32'(after1_valid), 32'd0);
    check("ent_done1",  32'(after1_done),  32'd1);
    check("ent_done2",  32'(after2_done),  32'd0);
    check("ent_dcyc",   32'(done_cyc - d0), 32'd2);

    // Escape: single cycle with reset
    base = q_data.size(); d0 = done_cyc; r0 = rst_cyc;
    send_frame(8'h76, 1'b0);
    check("esc_count", 32'(q_data.size() - base), 32'd1);
    check("esc_data",  32'(q_data[base]), 32'h1B);
    check("esc_reset", 32'(q_rst[base]),  32'd1);
    check("esc_rcyc",  32'(rst_cyc - r0), 32'd1);
    check("esc_nodone", 32'(done_cyc - d0), 32'd0);

    // Bad parity
    base = q_data.size(); e0 = err_cnt;
    send_frame(8'h16, 1'b1);
    check("par_err",   32'(err_cnt - e0), 32'd1);
    check("par_valid", 32'(q_data.size() - base), 32'd0);

    // Falling edge in IDLE with data high is a start-bit error
    e0 = err_cnt;
    send_bit(1'b1);
    wait_clks(GAP);
    check("start_err", 32'(err_cnt - e0), 32'd1);

    // Timeout after a partial frame, then recovery
    base = q_data.size(); e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_dat = 1'b1;
    wait_clks(int'(TO) + 100);
    check("to_err",   32'(err_cnt - e0), 32'd1);
    check("to_valid", 32'(q_data.size() - base), 32'd0);
    e0 = err_cnt;
    send_frame(8'h45, 1'b0);
    check("to_rec_count", 32'(q_data.size() - base), 32'd1);
    check("to_rec_data",  32'(q_data[base]), 32'h30);
    check("to_rec_noerr", 32'(err_cnt - e0), 32'd0);

    // Typematic repeats
    base = q_data.size();
    send_frame(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("typ_count", 32'(q_data.size() - base), 32'd2);
`else
    check("typ_count", 32'(q_data.size() - base), 32'd4);
`endif
    check("typ_first", 32'(q_data[base]), 32'h61);
    check("typ_last",  32'(q_data[q_data.size()-1]), 32'h61);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
